vu_vmu_dcache_arb: RTL and testbench
====================================

// Module: vu_vmu_dcache_arb
// PURPOSE
//  N-channel D$ request arbiter/response router for the VMU, generalising the fixed two-source (store-over-load) mux.
//  Arbitrates N requesters (load issue, store/AMO, prefetch, ...) onto one registered D$ request port.
//  Encodes {channel, addr_lsb, ctag} into the D$ tag and routes each response back to its channel, byte-aligned.
//  Tracks outstanding responses per channel and throttles each channel at MAX_OUT.
// PARAMETERS
//  NCH      2   number of requester channels (>=2); CH_W = clog2(NCH)
//  ADDR_W   30  D$ address width
//  DATA_W   64  D$ data width; wmask is DATA_W/8 bits
//  CTAG_W   8   per-channel tag width; CH_W+3+CTAG_W must be <= 12
//  MAX_OUT  16  max outstanding responses per channel; counter width clog2(MAX_OUT+1)
//  RR       0   0 = fixed priority (lowest index wins); 1 = round-robin
// PORTS
//  clk               in   1               clock
//  reset             in   1               synchronous, active-high reset
//  req_val           in   NCH             per-channel request valid
//  req_rdy           out  NCH             per-channel request accepted this cycle
//  req_addr          in   NCH*ADDR_W      per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//  req_lsb           in   NCH*3           per-channel byte offset, used for response alignment
//  req_tag           in   NCH*CTAG_W      per-channel tag
//  req_op            in   NCH*4           per-channel op: 4'b0000 load, 4'b0001 store, other = AMO
//  req_data          in   NCH*DATA_W      per-channel store/AMO data
//  req_wmask         in   NCH*DATA_W/8    per-channel write mask
//  dcachereq_val     out  1               registered D$ request valid
//  dcachereq_rdy     in   1               D$ ready
//  dcachereq_addr    out  ADDR_W          D$ address
//  dcachereq_tag     out  12              {zero pad, ch, lsb, ctag}
//  dcachereq_op      out  4               D$ op
//  dcachereq_data    out  DATA_W          D$ write data
//  dcachereq_wmask   out  DATA_W/8        D$ write mask
//  dcacheresp_val    in   1               D$ response valid
//  dcacheresp_tag    in   12              D$ response tag
//  dcacheresp_data   in   DATA_W          D$ response data
//  resp_val          out  NCH             per-channel response valid (no backpressure)
//  resp_tag          out  CTAG_W          ctag field of the response
//  resp_data         out  DATA_W          dcacheresp_data >> (8*lsb), zero-filled
//  busy              out  NCH             channel i has outstanding count != 0
// BEHAVIOUR
//  - Reset clears dcachereq_val, all outstanding counters and the RR pointer (to 0). busy=0 and req_rdy=0 during reset.
//  - Output stage is a 1-entry register: load_en = ~dcachereq_val | dcachereq_rdy.
//  - eligible[i] = req_val[i] & (cnt[i] < MAX_OUT | req_op[i]==4'b0001).
//  - RR=0: grant the lowest eligible index. RR=1: grant the first eligible index at or after ptr (mod NCH).
//  - req_rdy[i] = grant[i] & load_en & ~reset. At most one req_rdy is high per cycle.
//  - Fire (req_val & req_rdy) loads the register. dcachereq_val is high the next cycle (latency 1).
//  - Request fields are held stable while dcachereq_val & ~dcachereq_rdy.
//  - If load_en and nothing is granted, dcachereq_val goes to 0.
//  - RR pointer update on fire of channel g: ptr <= (g==NCH-1) ? 0 : g+1. With no fire, ptr holds.
//  - A response is expected for every op except 4'b0001. cnt[i] increments on fire of a non-store on channel i.
//  - cnt[i] decrements on dcacheresp_val with tag channel == i. Simultaneous increment and decrement leave cnt unchanged.
//  - A decrement at cnt==0 saturates at 0 (covers stale responses after reset mid-operation).
//  - Response path is combinational, same cycle: resp_val[i] = dcacheresp_val & (tag[CH_W+3+CTAG_W-1 -: CH_W] == i).
//  - A response whose channel id is >= NCH is dropped: no resp_val, no counter change, $display in simulation.
//  - Stores at cnt==MAX_OUT are still eligible. Loads and AMOs are blocked until a response arrives.
// TESTING
//  1. NCH=2, RR=0: ch0 and ch1 valid every cycle, dcachereq_rdy=1 -> ch0 granted every cycle, ch1 starved, dcachereq_val high from cycle 2.
//  2. NCH=4, RR=1: all valid, rdy=1 -> grant order 0,1,2,3,0. Hold rdy=0 for 3 cycles -> fields stable and ptr unchanged.
//  3. MAX_OUT=2: ch1 issues 3 loads with no response -> third req_rdy stays 0. One response with ch=1 -> third load fires the next cycle.
//  4. Response with lsb=3, data 64'h8877665544332211 -> resp_data=64'h0000008877665544, resp_tag equals the original ctag.
//  5. Store-only traffic with MAX_OUT=1 -> never throttled, cnt stays 0, busy=0.
//  6. Assert reset with 2 loads outstanding, then deliver both responses -> cnt stays 0, busy=0, resp_val still pulses.

Source files
------------

// File: rtl/vu_vmu_dcache_arb_if.sv
// ---------------------------------------------------------------------------
// vu_vmu_dcache_arb_if
//   Bundle of every handshake/bus signal around the VMU D$ arbiter.
//   slave  : arbiter view. It takes requests and D$ responses, and it drives
//            the D$ request port, per-channel responses and busy.
//   master : environment view (requesters plus D$), the mirror of slave.
//   Signal groups:
//     req_*         per-channel request bus, channel i in slice i
//     dcachereq_*   registered D$ request port
//     dcacheresp_*  D$ response port
//     resp_*, busy  per-channel response / outstanding status
// ---------------------------------------------------------------------------
interface vu_vmu_dcache_arb_if #(
   parameter int NCH    = 2,
   parameter int ADDR_W = 30,
   parameter int DATA_W = 64,
   parameter int CTAG_W = 8
);
   localparam int MW = DATA_W / 8;

   logic [NCH-1:0]        req_val;
   logic [NCH-1:0]        req_rdy;
   logic [NCH*ADDR_W-1:0] req_addr;
   logic [NCH*3-1:0]      req_lsb;
   logic [NCH*CTAG_W-1:0] req_tag;
   logic [NCH*4-1:0]      req_op;
   logic [NCH*DATA_W-1:0] req_data;
   logic [NCH*MW-1:0]     req_wmask;

   logic                  dcachereq_val;
   logic                  dcachereq_rdy;
   logic [ADDR_W-1:0]     dcachereq_addr;
   logic [11:0]           dcachereq_tag;
   logic [3:0]            dcachereq_op;
   logic [DATA_W-1:0]     dcachereq_data;
   logic [MW-1:0]         dcachereq_wmask;

   logic                  dcacheresp_val;
   logic [11:0]           dcacheresp_tag;
   logic [DATA_W-1:0]     dcacheresp_data;

   logic [NCH-1:0]        resp_val;
   logic [CTAG_W-1:0]     resp_tag;
   logic [DATA_W-1:0]     resp_data;
   logic [NCH-1:0]        busy;

   modport slave (
      input  req_val, req_addr, req_lsb, req_tag, req_op, req_data, req_wmask,
      input  dcachereq_rdy, dcacheresp_val, dcacheresp_tag, dcacheresp_data,
      output req_rdy, dcachereq_val, dcachereq_addr, dcachereq_tag, dcachereq_op,
      output dcachereq_data, dcachereq_wmask, resp_val, resp_tag, resp_data, busy
   );

   modport master (
      output req_val, req_addr, req_lsb, req_tag, req_op, req_data, req_wmask,
      output dcachereq_rdy, dcacheresp_val, dcacheresp_tag, dcacheresp_data,
      input  req_rdy, dcachereq_val, dcachereq_addr, dcachereq_tag, dcachereq_op,
      input  dcachereq_data, dcachereq_wmask, resp_val, resp_tag, resp_data, busy
   );
endinterface

// File: rtl/vu_vmu_dcache_arb.sv
// ---------------------------------------------------------------------------
// vu_vmu_dcache_arb
//   N-channel D$ request arbiter and response router for the VMU.
//   - Arbitrates NCH requesters onto one registered D$ request port. Fixed
//     priority (RR=0) gives the lowest index priority. Round-robin (RR=1)
//     starts the search at a pointer.
//   - Builds the D$ tag as {zero pad, channel, byte offset, channel tag}.
//   - Routes each D$ response back to its channel in the same cycle, shifted
//     down by the byte offset that was stored in the tag.
//   - Counts outstanding responses per channel. Loads and AMOs stop at
//     MAX_OUT. Stores never return a response, so they are never throttled.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    vu_vmu_dcache_arb_if.slave (request, D$ and response buses)
// ---------------------------------------------------------------------------
module vu_vmu_dcache_arb #(
   parameter int NCH     = 2,
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 64,
   parameter int CTAG_W  = 8,
   parameter int MAX_OUT = 16,
   parameter int RR      = 0
) (
   input  logic               clk,
   input  logic               reset,
   vu_vmu_dcache_arb_if.slave bus
);
   localparam int CH_W  = $clog2(NCH);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int MW    = DATA_W / 8;
   localparam logic [3:0] OP_STORE = 4'b0001;

   logic [CNT_W-1:0]  cnt [NCH];
   logic [CH_W-1:0]   ptr;
   logic [NCH-1:0]    elig, inc_v, rsp_v, busy_v;
   logic              any_gnt, load_en, fire;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W:0]     pos;

   logic              q_val;
   logic [ADDR_W-1:0] q_addr, sel_addr;
   logic [11:0]       q_tag, sel_tag;
   logic [3:0]        q_op, sel_op;
   logic [DATA_W-1:0] q_data, sel_data;
   logic [MW-1:0]     q_wmask, sel_wmask;

   logic [CH_W-1:0]      rsp_ch;
   logic [2**CH_W-1:0]   ch_ok;
   logic                 rsp_hit;

   assign load_en = ~q_val | bus.dcachereq_rdy;
   assign fire    = any_gnt & load_en & ~reset;

   // Response decode. Channel ids that do not exist are masked off here, so
   // the response is dropped without touching any counter.
   assign rsp_ch  = bus.dcacheresp_tag[CTAG_W+3 +: CH_W];
   assign rsp_hit = bus.dcacheresp_val & ch_ok[rsp_ch];

   always_comb begin
      elig   = '0;
      rsp_v  = '0;
      busy_v = '0;
      inc_v  = '0;
      ch_ok  = '0;
      for (int j = 0; j < 2**CH_W; j++) ch_ok[j] = (j < NCH);
      for (int i = 0; i < NCH; i++) begin
         elig[i]   = bus.req_val[i] & ((cnt[i] < CNT_W'(MAX_OUT)) |
                                       (bus.req_op[i*4 +: 4] == OP_STORE));
         rsp_v[i]  = rsp_hit & (rsp_ch == CH_W'(i));
         busy_v[i] = (cnt[i] != '0) & ~reset;
         inc_v[i]  = fire & (gnt_idx == CH_W'(i)) & (sel_op != OP_STORE);
      end
   end

   // Grant search. In fixed-priority mode the search starts at 0. In
   // round-robin mode it starts at ptr and wraps modulo NCH.
   // NOTE: the combinational blocks use blocking '=' and assign a default to
   // every output first, so no latch is inferred. The clocked blocks use
   // '<=' only.
   always_comb begin
      any_gnt = 1'b0;
      gnt_idx = '0;
      pos     = '0;
      for (int k = 0; k < NCH; k++) begin
         pos = (RR != 0) ? ({1'b0, ptr} + (CH_W+1)'(k)) : (CH_W+1)'(k);
         if (pos >= (CH_W+1)'(NCH)) pos = pos - (CH_W+1)'(NCH);
         if (!any_gnt && elig[pos[CH_W-1:0]]) begin
            any_gnt = 1'b1;
            gnt_idx = pos[CH_W-1:0];
         end
      end
   end

   always_comb begin
      sel_tag                   = '0;
      sel_addr                  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
      sel_op                    = bus.req_op[gnt_idx*4 +: 4];
      sel_data                  = bus.req_data[gnt_idx*DATA_W +: DATA_W];
      sel_wmask                 = bus.req_wmask[gnt_idx*MW +: MW];
      sel_tag[CTAG_W-1:0]       = bus.req_tag[gnt_idx*CTAG_W +: CTAG_W];
      sel_tag[CTAG_W +: 3]      = bus.req_lsb[gnt_idx*3 +: 3];
      sel_tag[CTAG_W+3 +: CH_W] = gnt_idx;
   end

   // Output register stage.
   // NOTE: only the valid bit and the pointer are reset. The payload is
   // qualified by q_val, so reset does not clear it.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_val <= 1'b0;
         ptr   <= '0;
      end else begin
         if (load_en) q_val <= fire;
         if (fire && RR != 0)
            ptr <= (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fire) begin
         q_addr  <= sel_addr;
         q_tag   <= sel_tag;
         q_op    <= sel_op;
         q_data  <= sel_data;
         q_wmask <= sel_wmask;
      end
   end

   // Outstanding counters. Increment and decrement in the same cycle cancel.
   // A decrement at 0 saturates, which absorbs responses that are still in
   // flight after a reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (inc_v[i] && !rsp_v[i])
               cnt[i] <= cnt[i] + 1'b1;
            else if (rsp_v[i] && !inc_v[i] && cnt[i] != '0)
               cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && bus.dcacheresp_val && !rsp_hit)
         $warning("vu_vmu_dcache_arb: dropped response for channel %0d", rsp_ch);
   end

   assign bus.req_rdy         = fire ? (NCH'(1) << gnt_idx) : '0;
   assign bus.dcachereq_val   = q_val;
   assign bus.dcachereq_addr  = q_addr;
   assign bus.dcachereq_tag   = q_tag;
   assign bus.dcachereq_op    = q_op;
   assign bus.dcachereq_data  = q_data;
   assign bus.dcachereq_wmask = q_wmask;
   assign bus.resp_val        = rsp_v;
   assign bus.resp_tag        = bus.dcacheresp_tag[CTAG_W-1:0];
   assign bus.resp_data       = bus.dcacheresp_data >> {bus.dcacheresp_tag[CTAG_W +: 3], 3'b000};
   assign bus.busy            = busy_v;
endmodule

// File: tb/tb_vu_vmu_dcache_arb.sv
// ---------------------------------------------------------------------------
// tb_vu_vmu_dcache_arb
//   Directed bench for three arbiter configurations:
//     dut_a : NCH=2, fixed priority, MAX_OUT=2
//     dut_b : NCH=4, round-robin, CTAG_W=7
//     dut_c : NCH=2, fixed priority, MAX_OUT=1
//   Inputs change 1 time unit after the rising edge. Combinational outputs
//   are sampled 1 unit after that.
// ---------------------------------------------------------------------------
module tb_vu_vmu_dcache_arb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   int   checks = 0;
   int   errors = 0;

   vu_vmu_dcache_arb_if #(.NCH(2), .CTAG_W(8)) ia ();
   vu_vmu_dcache_arb_if #(.NCH(4), .CTAG_W(7)) ib ();
   vu_vmu_dcache_arb_if #(.NCH(2), .CTAG_W(8)) ic ();

   vu_vmu_dcache_arb #(.NCH(2), .CTAG_W(8), .MAX_OUT(2), .RR(0))
      dut_a (.clk(clk), .reset(rst_a), .bus(ia));
   vu_vmu_dcache_arb #(.NCH(4), .CTAG_W(7), .MAX_OUT(16), .RR(1))
      dut_b (.clk(clk), .reset(rst_b), .bus(ib));
   vu_vmu_dcache_arb #(.NCH(2), .CTAG_W(8), .MAX_OUT(1), .RR(0))
      dut_c (.clk(clk), .reset(rst_c), .bus(ic));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] exp_tag;

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      ia.req_val = '0; ia.req_addr = '0; ia.req_lsb = '0; ia.req_tag = '0;
      ia.req_op = '0; ia.req_data = '0; ia.req_wmask = '0;
      ia.dcachereq_rdy = 1'b1; ia.dcacheresp_val = 1'b0;
      ia.dcacheresp_tag = '0; ia.dcacheresp_data = '0;
      ib.req_val = '0; ib.req_addr = '0; ib.req_lsb = '0; ib.req_tag = '0;
      ib.req_op = '0; ib.req_data = '0; ib.req_wmask = '0;
      ib.dcachereq_rdy = 1'b1; ib.dcacheresp_val = 1'b0;
      ib.dcacheresp_tag = '0; ib.dcacheresp_data = '0;
      ic.req_val = '0; ic.req_addr = '0; ic.req_lsb = '0; ic.req_tag = '0;
      ic.req_op = '0; ic.req_data = '0; ic.req_wmask = '0;
      ic.dcachereq_rdy = 1'b1; ic.dcacheresp_val = 1'b0;
      ic.dcacheresp_tag = '0; ic.dcacheresp_data = '0;

      // A: ch0 store, ch1 load, both valid. B: four loads, all valid.
      ia.req_addr[0 +: 30] = 30'h1234;  ia.req_lsb[0 +: 3] = 3'd2;
      ia.req_tag[0 +: 8]   = 8'h11;     ia.req_op[0 +: 4]  = 4'b0001;
      ia.req_data[0 +: 64] = 64'hDEADBEEF00000001; ia.req_wmask[0 +: 8] = 8'hF0;
      ia.req_addr[30 +: 30] = 30'h5678; ia.req_tag[8 +: 8] = 8'h22;
      ia.req_op[4 +: 4]     = 4'b0000;
      ia.req_val = 2'b11;
      for (int i = 0; i < 4; i++) begin
         ib.req_addr[i*30 +: 30] = 30'h100 + 30'(i);
         ib.req_lsb[i*3 +: 3]    = 3'(i);
         ib.req_tag[i*7 +: 7]    = 7'h10 + 7'(i);
         ib.req_op[i*4 +: 4]     = 4'b0000;
      end
      ib.req_val = 4'hF;

      // Reset state.
      tick(); #1;
      check("a_rst_rdy",  ia.req_rdy, 2'b00);
      check("a_rst_val",  ia.dcachereq_val, 1'b0);
      check("a_rst_busy", ia.busy, 2'b00);
      check("b_rst_rdy",  ib.req_rdy, 4'b0000);

      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      #1;
      // A starves ch1. B grants in the order 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         check("t1_gnt", ia.req_rdy, 2'b01);
         check("t2_gnt", ib.req_rdy, 4'b0001 << (k % 4));
         tick();
         check("t1_val", ia.dcachereq_val, 1'b1);
         check("t2_addr", ib.dcachereq_addr, 30'h100 + 30'(k % 4));
         exp_tag = 12'(((k % 4) << 10) | ((k % 4) << 7) | (16 + (k % 4)));
         check("t2_tag", ib.dcachereq_tag, exp_tag);
         #1;
      end
      check("t1_addr",  ia.dcachereq_addr, 30'h1234);
      check("t1_tag",   ia.dcachereq_tag, 12'h211);
      check("t1_op",    ia.dcachereq_op, 4'b0001);
      check("t1_data",  ia.dcachereq_data, 64'hDEADBEEF00000001);
      check("t1_wmask", ia.dcachereq_wmask, 8'hF0);

      // B stalled for 3 cycles: fields held, nothing accepted, pointer held.
      ib.dcachereq_rdy = 1'b0;
      ia.req_val = 2'b00;
      #1;
      check("t2_stall_rdy", ib.req_rdy, 4'b0000);
      for (int j = 0; j < 3; j++) begin
         tick();
         check("t2_stall_val",  ib.dcachereq_val, 1'b1);
         check("t2_stall_addr", ib.dcachereq_addr, 30'h100);
         check("t2_stall_tag",  ib.dcachereq_tag, 12'h010);
         check("t2_stall_rdy2", ib.req_rdy, 4'b0000);
      end
      check("t1_idle_val", ia.dcachereq_val, 1'b0);
      ib.dcachereq_rdy = 1'b1;
      #1;
      check("t2_resume_gnt", ib.req_rdy, 4'b0010);
      tick();
      check("t2_resume_addr", ib.dcachereq_addr, 30'h101);
      ib.req_val = 4'h0;

      // A: ch1 load with lsb=3, then its response is realigned.
      ia.req_addr[30 +: 30] = 30'h3ABC; ia.req_lsb[3 +: 3] = 3'd3;
      ia.req_tag[8 +: 8]    = 8'hA5;
      ia.req_val = 2'b10;
      #1;
      check("t4_gnt", ia.req_rdy, 2'b10);
      tick();
      ia.req_val = 2'b00;
      check("t4_dtag", ia.dcachereq_tag, 12'hBA5);
      check("t4_busy", ia.busy, 2'b10);
      ia.dcacheresp_val = 1'b1; ia.dcacheresp_tag = 12'hBA5;
      ia.dcacheresp_data = 64'h8877665544332211;
      #1;
      check("t4_rval", ia.resp_val, 2'b10);
      check("t4_rtag", ia.resp_tag, 8'hA5);
      check("t4_rdata", ia.resp_data, 64'h0000008877665544);
      tick();
      ia.dcacheresp_val = 1'b0;
      check("t4_busy_clr", ia.busy, 2'b00);

      // A: MAX_OUT=2 throttles the third load until a response arrives.
      ia.req_lsb[3 +: 3] = 3'd0; ia.req_tag[8 +: 8] = 8'h31;
      ia.req_val = 2'b10;
      #1;
      check("t3_load1", ia.req_rdy, 2'b10);
      tick();
      check("t3_load2", ia.req_rdy, 2'b10);
      tick();
      check("t3_load3_blk", ia.req_rdy, 2'b00);
      check("t3_busy", ia.busy, 2'b10);
      tick();
      check("t3_still_blk", ia.req_rdy, 2'b00);
      ia.dcacheresp_val = 1'b1; ia.dcacheresp_tag = 12'h800;
      #1;
      check("t3_rval", ia.resp_val, 2'b10);
      check("t3_blk_same_cyc", ia.req_rdy, 2'b00);
      tick();
      ia.dcacheresp_val = 1'b0;
      #1;
      check("t3_load3_go", ia.req_rdy, 2'b10);
      tick();
      ia.req_val = 2'b00;
      check("t3_full_again", ia.busy, 2'b10);
      ia.dcacheresp_val = 1'b1;
      tick(); tick();
      ia.dcacheresp_val = 1'b0;
      check("t3_drain", ia.busy, 2'b00);

      // A: reset with two loads outstanding, then stale responses arrive.
      ia.req_tag[0 +: 8] = 8'h44; ia.req_op[0 +: 4] = 4'b0000;
      ia.req_val = 2'b01;
      tick(); tick();
      ia.req_val = 2'b00;
      check("t6_busy_pre", ia.busy, 2'b01);
      #1;
      rst_a = 1'b1;
      ia.req_val = 2'b01;
      #1;
      check("t6_rst_busy", ia.busy, 2'b00);
      check("t6_rst_rdy", ia.req_rdy, 2'b00);
      tick();
      rst_a = 1'b0;
      ia.req_val = 2'b00;
      #1;
      check("t6_post_busy", ia.busy, 2'b00);
      check("t6_post_val", ia.dcachereq_val, 1'b0);
      ia.dcacheresp_val = 1'b1; ia.dcacheresp_tag = 12'h044;
      #1;
      check("t6_rval1", ia.resp_val, 2'b01);
      tick();
      check("t6_busy1", ia.busy, 2'b00);
      #1;
      check("t6_rval2", ia.resp_val, 2'b01);
      tick();
      ia.dcacheresp_val = 1'b0;
      check("t6_busy2", ia.busy, 2'b00);

      // C: stores only with MAX_OUT=1 are never throttled.
      ic.req_op = {4'b0001, 4'b0001};
      for (int k = 0; k < 6; k++) begin
         ic.req_val = (k < 3) ? 2'b01 : 2'b10;
         #1;
         check("t5_gnt", ic.req_rdy, (k < 3) ? 2'b01 : 2'b10);
         tick();
         check("t5_busy", ic.busy, 2'b00);
      end
      // C: one load fills ch1. A further load is blocked, a store still goes.
      ic.req_op[4 +: 4] = 4'b0000;
      #1;
      check("t5_load_gnt", ic.req_rdy, 2'b10);
      tick();
      check("t5_load_busy", ic.busy, 2'b10);
      check("t5_load_blk", ic.req_rdy, 2'b00);
      ic.req_op[4 +: 4] = 4'b0001;
      #1;
      check("t5_store_at_max", ic.req_rdy, 2'b10);
      tick();
      ic.req_val = 2'b00;
      check("t5_store_no_inc", ic.busy, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
